// File: rtl/frame_locked_display_arbiter.sv
// Frame-locked N-source display arbiter packing pixels into two SDRAM write words.
// Define TEST_PATTERN_EN to add an internal colour-bar source at select N_SRC.
module frame_locked_display_arbiter #(
   parameter int               N_SRC      = 4,
   parameter int               CH_W       = 12,
   parameter int               GRAY_W     = 8,
   parameter logic [N_SRC-1:0] GRAY_MASK  = 4'b0110,
   parameter int               EXP_PIXELS = 384000,
   parameter int               SEL_W      = 4
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   input  logic                    iFval,
   input  logic [15:0]             iX_Cont,
   input  logic [15:0]             iY_Cont,
   input  logic [N_SRC*3*CH_W-1:0] iSrcData,
   input  logic [N_SRC-1:0]        iSrcValid,
   input  logic [SEL_W-1:0]        iSelect,
   output logic [15:0]             oWr1_data,
   output logic [15:0]             oWr2_data,
   output logic                    oWr_data_valid,
   output logic [SEL_W-1:0]        oActiveSel,
   output logic [15:0]             oFrameCount,
   output logic [19:0]             oPixelCount,
   output logic                    oFrameErr
);

   localparam int PW = 3 * CH_W;

   logic            fval_d;
   logic            started;
   logic            frame_seen;
   logic            rise;
   logic            fall;
   logic            legal;
   logic [SEL_W-1:0] req_sel;
   logic [SEL_W-1:0] cur_sel;
   logic [PW-1:0]   mux_word;
   logic            mux_gray;
   logic            mux_valid;
   logic            s1_valid;
   logic            s1_gray;
   logic [PW-1:0]   s1_word;
   logic [CH_W-1:0] r;
   logic [CH_W-1:0] g;
   logic [CH_W-1:0] b;
   logic            end_d1;
   logic            end_d2;
   logic            unused_ok;

   function automatic logic [CH_W-1:0] expand(input logic [GRAY_W-1:0] gv);
      for (int k = 0; k < CH_W; k++)
         expand[CH_W-1-k] = gv[GRAY_W-1-(k % GRAY_W)];
   endfunction

   // A release of reset in mid-frame must not look like a frame start
   assign rise = iFval & ~fval_d & started;
   assign fall = ~iFval & fval_d;

`ifdef TEST_PATTERN_EN
   logic [9:0] bar_q;
   logic [2:0] bar;
   logic [PW-1:0] bar_word;

   always_comb begin
      bar_q    = iX_Cont[9:0] / 10'd80;
      bar      = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
      bar_word = {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}};
   end

   assign legal = (iSelect <= SEL_W'(N_SRC));
`else
   assign legal = (iSelect < SEL_W'(N_SRC));
`endif

   assign req_sel = legal ? iSelect : '0;
   assign cur_sel = rise ? req_sel : oActiveSel;

   always_comb begin
      mux_word  = '0;
      mux_gray  = 1'b0;
      mux_valid = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (cur_sel == SEL_W'(i)) begin
            mux_word  = iSrcData[i*PW +: PW];
            mux_gray  = GRAY_MASK[i];
            mux_valid = iSrcValid[i];
         end
      end
`ifdef TEST_PATTERN_EN
      if (cur_sel == SEL_W'(N_SRC)) begin
         mux_word  = bar_word;
         mux_gray  = 1'b0;
         mux_valid = 1'b1;
      end
`endif
   end

   always_comb begin
      if (s1_gray) begin
         r = expand(s1_word[GRAY_W-1:0]);
         g = r;
         b = r;
      end else begin
         r = s1_word[3*CH_W-1 -: CH_W];
         g = s1_word[2*CH_W-1 -: CH_W];
         b = s1_word[CH_W-1:0];
      end
   end

   assign unused_ok = ^{iY_Cont, iX_Cont, r[CH_W-11:0], g[CH_W-11:0], b[CH_W-11:0]};

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         fval_d         <= 1'b0;
         started        <= 1'b0;
         frame_seen     <= 1'b0;
         s1_valid       <= 1'b0;
         s1_gray        <= 1'b0;
         s1_word        <= '0;
         end_d1         <= 1'b0;
         end_d2         <= 1'b0;
         oWr1_data      <= '0;
         oWr2_data      <= '0;
         oWr_data_valid <= 1'b0;
         oActiveSel     <= '0;
         oFrameCount    <= '0;
         oPixelCount    <= '0;
         oFrameErr      <= 1'b0;
      end else begin
         started <= 1'b1;
         fval_d  <= iFval;
         if (rise) begin
            oActiveSel <= req_sel;
            frame_seen <= 1'b1;
         end
         s1_valid <= mux_valid & iFval;
         if (mux_valid & iFval) begin
            s1_word <= mux_word;
            s1_gray <= mux_gray;
         end
         oWr_data_valid <= s1_valid;
         if (s1_valid) begin
            oWr1_data <= {1'b0, g[CH_W-1 -: 5], b[CH_W-1 -: 10]};
            oWr2_data <= {1'b0, g[CH_W-6 -: 5], r[CH_W-1 -: 10]};
         end
         // Compare waits for the pixels still in flight at the falling edge
         end_d1 <= fall & frame_seen;
         end_d2 <= end_d1;
         if (end_d2) begin
            oFrameCount <= oFrameCount + 16'd1;
            oFrameErr   <= (oPixelCount != 20'(EXP_PIXELS));
         end
         if (rise)
            oPixelCount <= '0;
         else if (oWr_data_valid && oPixelCount != '1)
            oPixelCount <= oPixelCount + 20'd1;
      end
   end

endmodule
